// File: rtl/zeroheti_pkg.sv
// zeroheti_pkg
// Shared types and address-map constants for the zeroHETI core. The APB
// bridge and the core's peripheral address rule both use the constants
// below, so the decoded windows and the crossbar rule always agree.
package zeroheti_pkg;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2,
        APB_RESP   = 2'd3
    } apb_bridge_state_e;

    localparam logic [31:0] ApbBaseAddr = 32'h0003_0000;
    localparam logic [31:0] ApbSbrSize  = 32'h0000_1000;
    localparam int unsigned ApbNumSbr   = 4;

    // Inclusive upper bound of the peripheral region.
    localparam logic [31:0] ApbEndAddr  = ApbBaseAddr + ApbNumSbr * ApbSbrSize - 32'd1;

    // Width of a subordinate index; a single subordinate still needs one bit.
    function automatic int unsigned apb_idx_width(input int unsigned num_sbr);
        return (num_sbr > 1) ? $clog2(num_sbr) : 1;
    endfunction

endpackage

// File: rtl/zeroheti_apb_decoder.sv
// zeroheti_apb_decoder
// Combinational address decoder for the APB bridge: maps an address to the
// subordinate window that owns it.
// Ports:
//   addr_i : byte address from the OBI request
//   idx_o  : index of the owning subordinate (valid only when hit_o = 1)
//   hit_o  : address falls inside one of the NumApbSbr windows
module zeroheti_apb_decoder
    import zeroheti_pkg::*;
#(
    parameter int unsigned NumApbSbr = ApbNumSbr,
    parameter logic [31:0] BaseAddr  = ApbBaseAddr,
    parameter logic [31:0] SbrSize   = ApbSbrSize
) (
    input  logic [31:0]                           addr_i,
    output logic [apb_idx_width(NumApbSbr)-1:0]   idx_o,
    output logic                                  hit_o
);

    localparam int unsigned IdxW     = apb_idx_width(NumApbSbr);
    localparam int unsigned SbrShift = $clog2(SbrSize);

    logic [31:0] offset;
    logic [31:0] window;

    // Addresses below BaseAddr wrap to a huge offset; the explicit >= test
    // keeps them out of range rather than letting the wrap alias a window.
    always_comb begin
        offset = addr_i - BaseAddr;
        window = offset >> SbrShift;
        hit_o  = (addr_i >= BaseAddr) && (window < NumApbSbr);
        idx_o  = window[IdxW-1:0];
    end

endmodule

// File: rtl/zeroheti_apb_bridge.sv
// zeroheti_apb_bridge
// OBI-to-APB4 bridge with an N-way subordinate demux for the peripheral
// region. One transaction is outstanding at a time.
// Ports:
//   clk_i, rst_ni             : clock, asynchronous active-low reset
//   req_i/gnt_o, addr_i, we_i,
//   be_i, wdata_i             : OBI A channel
//   rvalid_o, rdata_o, err_o  : OBI R channel (valid for one cycle)
//   paddr_o, psel_o, penable_o,
//   pwrite_o, pstrb_o,
//   pwdata_o, pprot_o         : APB request, psel_o one-hot per subordinate
//   prdata_i, pready_i,
//   pslverr_i                 : per-subordinate APB response
//   err_count_o               : saturating count of error responses
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for req_i; grants combinationally
// SETUP  | APB setup phase, PSEL high, PENABLE low (one cycle)
// ACCESS | PENABLE high, waiting for PREADY or timeout
// RESP   | rvalid_o high with captured rdata/err (one cycle)
module zeroheti_apb_bridge
    import zeroheti_pkg::*;
#(
    parameter int unsigned NumApbSbr     = ApbNumSbr,
    parameter logic [31:0] BaseAddr      = ApbBaseAddr,
    parameter logic [31:0] SbrSize       = ApbSbrSize,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          req_i,
    output logic                          gnt_o,
    input  logic [31:0]                   addr_i,
    input  logic                          we_i,
    input  logic [3:0]                    be_i,
    input  logic [31:0]                   wdata_i,
    output logic                          rvalid_o,
    output logic [31:0]                   rdata_o,
    output logic                          err_o,
    output logic [31:0]                   paddr_o,
    output logic [NumApbSbr-1:0]          psel_o,
    output logic                          penable_o,
    output logic                          pwrite_o,
    output logic [3:0]                    pstrb_o,
    output logic [31:0]                   pwdata_o,
    output logic [2:0]                    pprot_o,
    input  logic [NumApbSbr-1:0][31:0]    prdata_i,
    input  logic [NumApbSbr-1:0]          pready_i,
    input  logic [NumApbSbr-1:0]          pslverr_i,
    output logic [7:0]                    err_count_o
);

    localparam int unsigned IdxW = apb_idx_width(NumApbSbr);
    localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntW-1:0] CntMax  = CntW'(TimeoutCycles);
    localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

    apb_bridge_state_e state_q, state_d;

    logic [29:0]     addr_q, addr_d;
    logic            we_q, we_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [7:0]      errcnt_q, errcnt_d;

    logic [IdxW-1:0] dec_idx;
    logic            dec_hit;
    logic            apb_active;
    logic            timeout;

    zeroheti_apb_decoder #(
        .NumApbSbr (NumApbSbr),
        .BaseAddr  (BaseAddr),
        .SbrSize   (SbrSize)
    ) i_decoder (
        .addr_i (addr_i),
        .idx_o  (dec_idx),
        .hit_o  (dec_hit)
    );

    // cnt_q holds the number of ACCESS cycles already completed, so it equals
    // CntLast during the TimeoutCycles-th ACCESS cycle.
    assign timeout = (TimeoutCycles != 0) && (cnt_q == CntLast);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= APB_IDLE;
            addr_q   <= '0;
            we_q     <= 1'b0;
            be_q     <= '0;
            wdata_q  <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            errcnt_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            be_q     <= be_d;
            wdata_q  <= wdata_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            errcnt_q <= errcnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_d      = err_q;
        errcnt_d   = errcnt_q;
        apb_active = 1'b0;

        gnt_o     = 1'b0;
        rvalid_o  = 1'b0;
        rdata_o   = '0;
        err_o     = 1'b0;
        psel_o    = '0;
        penable_o = 1'b0;
        paddr_o   = '0;
        pwrite_o  = 1'b0;
        pstrb_o   = '0;
        pwdata_o  = '0;
        pprot_o   = '0;

        unique case (state_q)
            APB_IDLE: begin
                gnt_o = req_i;
                if (req_i) begin
                    addr_d  = addr_i[31:2];
                    we_d    = we_i;
                    be_d    = be_i;
                    wdata_d = wdata_i;
                    idx_d   = dec_idx;
                    cnt_d   = '0;
                    if (dec_hit) begin
                        state_d = APB_SETUP;
                    end else begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = APB_RESP;
                    end
                end
            end
            APB_SETUP: begin
                apb_active = 1'b1;
                state_d    = APB_ACCESS;
            end
            APB_ACCESS: begin
                apb_active = 1'b1;
                penable_o  = 1'b1;
                if (cnt_q != CntMax) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // A late PREADY coinciding with expiry still completes normally.
                if (pready_i[idx_q]) begin
                    rdata_d = we_q ? 32'd0 : prdata_i[idx_q];
                    err_d   = pslverr_i[idx_q];
                    state_d = APB_RESP;
                end else if (timeout) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = APB_RESP;
                end
            end
            APB_RESP: begin
                rvalid_o = 1'b1;
                rdata_o  = rdata_q;
                err_o    = err_q;
                if (err_q && (errcnt_q != 8'hFF)) begin
                    errcnt_d = errcnt_q + 8'd1;
                end
                state_d = APB_IDLE;
            end
            default: state_d = APB_IDLE;
        endcase

        if (apb_active) begin
            psel_o[idx_q] = 1'b1;
            paddr_o       = {addr_q, 2'b00};
            pwrite_o      = we_q;
            pstrb_o       = we_q ? be_q : 4'b0000;
            pwdata_o      = we_q ? wdata_q : 32'd0;
        end
    end

    assign err_count_o = errcnt_q;

endmodule

// File: tb/tb_zeroheti_apb_bridge.sv
// tb_zeroheti_apb_bridge
// Directed bench for the OBI-to-APB bridge: 4 subordinates, 4 KiB windows at
// 0x0003_0000, timeout of 8 ACCESS cycles. Inputs change on the falling edge,
// outputs are sampled on the falling edge (or just after an input change).
module tb_zeroheti_apb_bridge;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic              req_i = 1'b0;
    logic              gnt_o;
    logic [31:0]       addr_i = '0;
    logic              we_i = 1'b0;
    logic [3:0]        be_i = '0;
    logic [31:0]       wdata_i = '0;
    logic              rvalid_o;
    logic [31:0]       rdata_o;
    logic              err_o;
    logic [31:0]       paddr_o;
    logic [3:0]        psel_o;
    logic              penable_o;
    logic              pwrite_o;
    logic [3:0]        pstrb_o;
    logic [31:0]       pwdata_o;
    logic [2:0]        pprot_o;
    logic [3:0][31:0]  prdata_i;
    logic [3:0]        pready_i = '0;
    logic [3:0]        pslverr_i = '0;
    logic [7:0]        err_count_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    zeroheti_apb_bridge #(
        .NumApbSbr     (4),
        .BaseAddr      (32'h0003_0000),
        .SbrSize       (32'h0000_1000),
        .TimeoutCycles (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_i       (req_i),
        .gnt_o       (gnt_o),
        .addr_i      (addr_i),
        .we_i        (we_i),
        .be_i        (be_i),
        .wdata_i     (wdata_i),
        .rvalid_o    (rvalid_o),
        .rdata_o     (rdata_o),
        .err_o       (err_o),
        .paddr_o     (paddr_o),
        .psel_o      (psel_o),
        .penable_o   (penable_o),
        .pwrite_o    (pwrite_o),
        .pstrb_o     (pstrb_o),
        .pwdata_o    (pwdata_o),
        .pprot_o     (pprot_o),
        .prdata_i    (prdata_i),
        .pready_i    (pready_i),
        .pslverr_i   (pslverr_i),
        .err_count_o (err_count_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_quiet(input string tag, input logic [7:0] exp_cnt);
        check_eq({tag, ".psel"},    psel_o,      0);
        check_eq({tag, ".penable"}, penable_o,   0);
        check_eq({tag, ".paddr"},   paddr_o,     0);
        check_eq({tag, ".pwrite"},  pwrite_o,    0);
        check_eq({tag, ".pstrb"},   pstrb_o,     0);
        check_eq({tag, ".pwdata"},  pwdata_o,    0);
        check_eq({tag, ".pprot"},   pprot_o,     0);
        check_eq({tag, ".rvalid"},  rvalid_o,    0);
        check_eq({tag, ".rdata"},   rdata_o,     0);
        check_eq({tag, ".err"},     err_o,       0);
        check_eq({tag, ".errcnt"},  err_count_o, exp_cnt);
    endtask

    // In-range transfer: grant at T, SETUP at T+1, `waits` ACCESS cycles with
    // PREADY low, then PREADY on the next ACCESS cycle, rvalid at T+3+waits.
    // Unselected subordinates drive PREADY/PSLVERR high to prove they are ignored.
    task automatic run_xfer(input string tag, input logic [31:0] addr, input logic we,
                            input logic [3:0] be, input logic [31:0] wdata, input int sbr,
                            input int waits, input logic [31:0] rd, input logic slverr);
        logic [3:0] sel;
        sel = 4'b0001 << sbr;
        @(negedge clk_i);
        req_i = 1'b1; addr_i = addr; we_i = we; be_i = be; wdata_i = wdata;
        pready_i = '0; pslverr_i = 4'hF;
        #1 check_eq({tag, ".gnt"}, gnt_o, 1);
        @(negedge clk_i);
        check_eq({tag, ".setup_psel"},    psel_o,    sel);
        check_eq({tag, ".setup_penable"}, penable_o, 0);
        check_eq({tag, ".paddr"},         paddr_o,   {addr[31:2], 2'b00});
        check_eq({tag, ".pwrite"},        pwrite_o,  we);
        check_eq({tag, ".pstrb"},         pstrb_o,   we ? be : 4'b0);
        check_eq({tag, ".pwdata"},        pwdata_o,  we ? wdata : 32'd0);
        check_eq({tag, ".pprot"},         pprot_o,   0);
        check_eq({tag, ".busy_gnt"},      gnt_o,     0);
        req_i = 1'b0;
        for (int i = 0; i <= waits; i++) begin
            @(negedge clk_i);
            check_eq({tag, ".access_penable"}, penable_o, 1);
            check_eq({tag, ".access_psel"},    psel_o,    sel);
            check_eq({tag, ".access_rvalid"},  rvalid_o,  0);
            if (i == waits) begin
                pready_i       = sel;
                prdata_i[sbr]  = rd;
                pslverr_i[sbr] = slverr;
            end else begin
                pready_i = ~sel;
            end
        end
        @(negedge clk_i);
        pready_i = '0; pslverr_i = '0;
        check_eq({tag, ".rvalid"},       rvalid_o,  1);
        check_eq({tag, ".err"},          err_o,     slverr);
        check_eq({tag, ".rdata"},        rdata_o,   we ? 32'd0 : rd);
        check_eq({tag, ".resp_psel"},    psel_o,    0);
        check_eq({tag, ".resp_penable"}, penable_o, 0);
        @(negedge clk_i);
        check_eq({tag, ".after_rvalid"}, rvalid_o, 0);
        check_eq({tag, ".after_rdata"},  rdata_o,  0);
    endtask

    // Out-of-range read: rvalid with err at T+1, no PSEL.
    task automatic dec_err(input string tag, input logic [31:0] addr);
        @(negedge clk_i);
        req_i = 1'b1; addr_i = addr; we_i = 1'b0; be_i = 4'hF;
        #1 check_eq({tag, ".gnt"}, gnt_o, 1);
        @(negedge clk_i);
        req_i = 1'b0;
        check_eq({tag, ".rvalid"}, rvalid_o, 1);
        check_eq({tag, ".err"},    err_o,    1);
        check_eq({tag, ".rdata"},  rdata_o,  0);
        check_eq({tag, ".psel"},   psel_o,   0);
        @(negedge clk_i);
        check_eq({tag, ".after_rvalid"}, rvalid_o, 0);
    endtask

    initial begin
        prdata_i[0] = 32'hBAD0_0000;
        prdata_i[1] = 32'hBAD0_0001;
        prdata_i[2] = 32'hBAD0_0002;
        prdata_i[3] = 32'hBAD0_0003;

        #1 check_quiet("reset", 8'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        // Zero-wait write to subordinate 1.
        run_xfer("wr1", 32'h0003_1008, 1'b1, 4'b0011, 32'hDEAD_BEEF, 1, 0, 32'h0, 1'b0);
        // Read from subordinate 3 with two wait states.
        run_xfer("rd3", 32'h0003_3004, 1'b0, 4'b1111, 32'h0, 3, 2, 32'h1234_5678, 1'b0);
        check_eq("errcnt_ok", err_count_o, 0);

        dec_err("dec_idx4", 32'h0003_4000);
        check_eq("errcnt_dec1", err_count_o, 1);
        dec_err("dec_below", 32'h0002_FFFC);
        check_eq("errcnt_dec2", err_count_o, 2);

        // Subordinate 0 never answers: abort after 8 ACCESS cycles.
        @(negedge clk_i);
        req_i = 1'b1; addr_i = 32'h0003_0010; we_i = 1'b0; be_i = 4'hF;
        pready_i = 4'hE; pslverr_i = 4'hE;
        #1 check_eq("to.gnt", gnt_o, 1);
        @(negedge clk_i);
        req_i = 1'b0;
        check_eq("to.setup_psel", psel_o, 4'b0001);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            check_eq("to.penable", penable_o, 1);
            check_eq("to.psel",    psel_o,    4'b0001);
            check_eq("to.rvalid",  rvalid_o,  0);
        end
        @(negedge clk_i);
        check_eq("to.end_psel",    psel_o,    0);
        check_eq("to.end_penable", penable_o, 0);
        check_eq("to.rvalid_end",  rvalid_o,  1);
        check_eq("to.err",         err_o,     1);
        check_eq("to.rdata",       rdata_o,   0);
        pready_i = '0; pslverr_i = '0;
        @(negedge clk_i);
        check_eq("errcnt_to", err_count_o, 3);

        // PREADY on the 8th ACCESS cycle beats the timeout.
        run_xfer("late8", 32'h0003_0020, 1'b0, 4'hF, 32'h0, 0, 7, 32'h55AA_33CC, 1'b0);
        check_eq("errcnt_late", err_count_o, 3);

        // PSLVERR from subordinate 2.
        run_xfer("slverr2", 32'h0003_2100, 1'b0, 4'hF, 32'h0, 2, 1, 32'hA5A5_0F0F, 1'b1);
        check_eq("errcnt_slverr", err_count_o, 4);

        // 300 forced errors: counter saturates at 255.
        for (int i = 0; i < 251; i++) dec_err("sat", 32'h0004_0000);
        check_eq("errcnt_255", err_count_o, 255);
        for (int i = 0; i < 49; i++) dec_err("sat", 32'h0000_0000);
        check_eq("errcnt_sat", err_count_o, 255);

        // Asynchronous reset in the middle of ACCESS.
        @(negedge clk_i);
        req_i = 1'b1; addr_i = 32'h0003_1000; we_i = 1'b1; be_i = 4'hF; wdata_i = 32'h0F0F_F0F0;
        @(negedge clk_i);
        req_i = 1'b0;
        @(negedge clk_i);
        check_eq("rst.pre_penable", penable_o, 1);
        #2 rst_ni = 1'b0;
        #1 check_quiet("rst_mid", 8'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        run_xfer("post_rst", 32'h0003_0004, 1'b0, 4'hF, 32'h0, 0, 0, 32'hCAFE_0001, 1'b0);
        check_eq("errcnt_post_rst", err_count_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/zeroheti_apb_bridge.md
# zeroheti_apb_bridge

Parametrised OBI-to-APB4 bridge with an N-way subordinate demux, for the zeroHETI core's peripheral region. It sits on one crossbar manager port and fans out to `NumApbSbr` APB subordinates (UART, mtimer, …), each owning one fixed-size address window. Unlike a single-select bridge, it:
- decodes per-subordinate `PSEL`;
- returns OBI errors for unmapped addresses and for `PSLVERR`;
- aborts hung transfers with a wait-state timeout;
- counts errors.

## Interface
Parameters:
- `NumApbSbr`, 4: number of APB subordinates (1..16).
- `BaseAddr`, 32'h0003_0000: start of subordinate 0's window.
- `SbrSize`, 32'h0000_1000: bytes per window. Must be a power of two, ≥ 4.
- `TimeoutCycles`, 255: maximum ACCESS cycles before abort. 0 disables the timeout.

Ports:
- `clk_i` in 1: single clock.
- `rst_ni` in 1: asynchronous, active-low reset.
- `req_i` / `gnt_o` in/out 1: OBI A-channel handshake.
- `addr_i` in 32, `we_i` in 1, `be_i` in 4, `wdata_i` in 32: OBI request fields.
- `rvalid_o` out 1, `rdata_o` out 32, `err_o` out 1: OBI R-channel.
- `paddr_o` out 32, `psel_o` out NumApbSbr, `penable_o` out 1, `pwrite_o` out 1: APB request.
- `pstrb_o` out 4, `pwdata_o` out 32, `pprot_o` out 3: APB request data and attributes.
- `prdata_i` in NumApbSbr×32, `pready_i` in NumApbSbr, `pslverr_i` in NumApbSbr: per-subordinate APB response.
- `err_count_o` out 8: saturating count of error responses.

## Operation
FSM states: IDLE, SETUP, ACCESS, RESP.

IDLE:
- `gnt_o = req_i` (combinational). No other state grants.
- On `req_i & gnt_o`, the bridge registers `addr_i`, `we_i`, `be_i` and `wdata_i`, and computes `idx = (addr_i - BaseAddr) >> log2(SbrSize)`.
- In range (`addr_i >= BaseAddr` and `idx < NumApbSbr`): go to SETUP.
- Out of range: go to RESP with error flag = 1 and rdata = 0. No APB activity occurs.

SETUP (exactly 1 cycle):
- `psel_o[idx] = 1`, `penable_o = 0`.
- `paddr_o = {addr[31:2], 2'b00}`.
- `pwrite_o = we`.
- `pstrb_o = we ? be : 4'b0`.
- `pwdata_o = we ? wdata : 0`.
- `pprot_o = 3'b000`.
- Next state: ACCESS.

ACCESS:
- Same as SETUP, plus `penable_o = 1`. The timeout counter increments each cycle.
- On `pready_i[idx]`: capture rdata = `we ? 0 : prdata_i[idx]` and error flag = `pslverr_i[idx]`, then go to RESP.
- If the counter reaches `TimeoutCycles` (and `TimeoutCycles != 0`) without `pready_i[idx]`: deassert PSEL/PENABLE, set error flag = 1 and rdata = 0, go to RESP.
- `pready_i` and `pslverr_i` of unselected subordinates are ignored.

RESP (exactly 1 cycle):
- `rvalid_o = 1` with registered `rdata_o` and `err_o`.
- If `err_o`, `err_count_o` increments, saturating at 255.
- Next state: IDLE.

Outside RESP, `rvalid_o`, `rdata_o` and `err_o` are 0. APB outputs are 0 whenever `psel_o == 0`.

## Timing
- Reset (asynchronous, any state, including mid-ACCESS): state = IDLE, counter = 0, `err_count_o` = 0. All outputs are 0 except `gnt_o`, which follows `req_i` once out of reset.
- A subordinate left mid-transfer by reset sees PSEL drop; no response is returned.
- Grant in cycle T, in-range transfer:
  - SETUP at T+1, ACCESS at T+2.
  - Zero-wait `pready` at T+2 gives `rvalid_o` at T+3.
  - Each wait state adds 1 cycle.
  - Next grant is possible at T+4. Throughput: 1 transfer per 4 cycles at zero wait.
- Decode error: `rvalid_o` with `err_o = 1` at T+1, next grant at T+2.
- Timeout: `pready` is low for ACCESS cycles 1..`TimeoutCycles`, abort at the last such cycle, `rvalid_o` on the following cycle.
- `pready_i` arriving in the same cycle the counter expires: `pready` wins, and the normal response (possibly `pslverr`) is returned.
- Timeout counter width: `$clog2(TimeoutCycles+1)`. It is cleared on entry to SETUP and never wraps.
- Address arithmetic is 32-bit unsigned. An address below `BaseAddr` underflows and is treated as out of range, not wrapped.
- Only one transaction is ever outstanding, so `req_i` while busy is simply not granted.

## Structure
- `zeroheti_pkg` gains:
  - the bridge state enum `apb_bridge_state_e`;
  - the default constants `ApbBaseAddr`, `ApbSbrSize` and `ApbNumSbr`, so the core address map and the bridge share them. The core's peripheral address rule becomes `[ApbBaseAddr, ApbBaseAddr + ApbNumSbr*ApbSbrSize - 1]`.
- One sub-module, `zeroheti_apb_decoder`: purely combinational; `addr` → (`idx`, `hit`), parametrised as above.
- Everything else (FSM, request registers, timeout counter, error counter) lives in the top module.

## Test plan
Configuration for all scenarios: NumApbSbr=4, BaseAddr=0x0003_0000, SbrSize=0x1000, TimeoutCycles=8.
- Write 0xDEADBEEF, be=4'b0011, to 0x0003_1008, zero-wait → `psel_o=4'b0010` at T+1, `penable_o` at T+2, `pstrb_o=4'b0011`, `paddr_o=0x0003_1008`, `rvalid_o` at T+3 with `err_o=0`.
- Read 0x0003_3004, subordinate 3 inserts 2 wait states and returns 0x1234_5678 → `rvalid_o` at T+5, `rdata_o=0x1234_5678`, `pstrb_o=0`.
- Read 0x0003_4000 (idx 4) and read 0x0002_FFFC → each returns `rvalid_o` at T+1 with `err_o=1` and `rdata_o=0`; `psel_o` never asserts; `err_count_o` goes 0→2.
- Subordinate 0 holds `pready=0` indefinitely → `penable_o` high for exactly 8 cycles, then PSEL drops and `rvalid_o` asserts with `err_o=1`. A separate run with `pready` rising on the 8th cycle returns `err_o=0`.
- Subordinate 2 replies with `pslverr=1` → `err_o=1`. 300 forced errors → `err_count_o` saturates at 255.
- Assert `rst_ni=0` during ACCESS → all outputs are 0 immediately. After release, a new request is granted the same cycle it is presented.
